// File: rtl/bp_pkg.sv
// Shared types and helpers for the parametrised local-history branch predictor.
// Holds the counter-width default, the weak-taken init value, the saturating
// counter update, the PHT index hash and the table-init FSM state type.
package bp_pkg;

  // Default and widest supported saturating-counter widths
  localparam int CNT_W_DEF   = 2;
  localparam int CNT_W_MAX   = 8;
  // Widest supported PHT index (helper functions work at this width)
  localparam int PHT_IDX_MAX = 16;

  // Table-init FSM states
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_e;

  // Weak-taken counter value: only the MSB set
  function automatic logic [CNT_W_MAX-1:0] weak_taken(input int cnt_w);
    return CNT_W_MAX'(1) << (cnt_w - 1);
  endfunction

  // Saturating up/down step of a cnt_w-bit counter carried in CNT_W_MAX bits
  function automatic logic [CNT_W_MAX-1:0] sat_next(input logic [CNT_W_MAX-1:0] cnt,
                                                    input logic                 taken,
                                                    input int                   cnt_w);
    logic [CNT_W_MAX-1:0] top;
    top = (CNT_W_MAX'(1) << cnt_w) - CNT_W_MAX'(1);
    if (taken) begin
      return (cnt >= top) ? top : cnt + CNT_W_MAX'(1);
    end
    return (cnt == '0) ? '0 : cnt - CNT_W_MAX'(1);
  endfunction

  // PHT index: plain history, or history folded with the PC index bits
  function automatic logic [PHT_IDX_MAX-1:0] pht_hash(input logic [PHT_IDX_MAX-1:0] hist,
                                                      input logic [PHT_IDX_MAX-1:0] pc_bits,
                                                      input int                     mode);
    return (mode == 1) ? (hist ^ pc_bits) : hist;
  endfunction

endpackage

// File: rtl/bp_table_init.sv
// Sequential table-initialisation FSM for the local predictor.
// After reset it sweeps an index over every table slot, one per cycle, then
// parks in RUN until the next reset. A reset mid-sweep restarts from index 0.
module bp_table_init
  import bp_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  output logic             o_init_we,
  output logic [IDX_W-1:0] o_init_idx,
  output logic             o_ready
);

  bp_state_e        r_state;
  bp_state_e        w_state_next;
  logic [IDX_W-1:0] r_idx;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= INIT;
    else     r_state <= w_state_next;
  end

  // Next state: leave INIT once the last slot has been written
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      INIT:    if (r_idx == '1) w_state_next = RUN;
      RUN:     w_state_next = RUN;
      default: w_state_next = INIT;
    endcase
  end

  // Sweep index advances only while initialising
  always_ff @(posedge clk) begin
    if (rst)                  r_idx <= '0;
    else if (r_state == INIT) r_idx <= r_idx + 1'b1;
  end

  // Outputs decoded from state
  always_comb begin
    o_init_we = (r_state == INIT);
    o_ready   = (r_state == RUN);
  end

  assign o_init_idx = r_idx;

endmodule

// File: rtl/branch_predict_local_param.sv
// Parametrised two-level local-history branch direction predictor.
// BHT (per-PC history) and PHT (saturating counters) are looked up at F,
// the prediction is registered into D, and training happens at M.
// Optional performance counters are built when BP_LOCAL_PERF_EN is defined.
module branch_predict_local_param
  import bp_pkg::*;
#(
  parameter int PC_LSB    = 2,
  parameter int BHT_IDX_W = 10,
  parameter int HIST_W    = 6,
  parameter int PHT_IDX_W = 6,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int HASH_MODE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallD,
  input  logic        flushD,
  input  logic [31:0] pcF,
  input  logic        branchD,
  input  logic [31:0] pcM,
  input  logic        branchM,
  input  logic        actual_takeM,
  input  logic        pred_takeM,
  output logic        pred_takeD,
  output logic        ready,
  output logic [31:0] perf_br_cnt,
  output logic [31:0] perf_mis_cnt
);

  localparam int INIT_W = (BHT_IDX_W > PHT_IDX_W) ? BHT_IDX_W : PHT_IDX_W;
  localparam int BHT_N  = 1 << BHT_IDX_W;
  localparam int PHT_N  = 1 << PHT_IDX_W;
  localparam logic [CNT_W-1:0] PHT_INIT = CNT_W'(weak_taken(CNT_W));

  // Tables: async read, sync write, no reset (filled by the init sweep)
  logic [HIST_W-1:0] r_bht [BHT_N];
  logic [CNT_W-1:0]  r_pht [PHT_N];

  // Init sweep
  logic              w_init_we;
  logic [INIT_W-1:0] w_init_idx;
  logic              w_ready;
  logic              w_init_bht_ok;
  logic              w_init_pht_ok;

  bp_table_init #(
    .IDX_W (INIT_W)
  ) u_init (
    .clk        (clk),
    .rst        (rst),
    .o_init_we  (w_init_we),
    .o_init_idx (w_init_idx),
    .o_ready    (w_ready)
  );

  // The sweep covers the larger table; the smaller one only takes in-range slots
  assign w_init_bht_ok = ((w_init_idx >> BHT_IDX_W) == '0);
  assign w_init_pht_ok = ((w_init_idx >> PHT_IDX_W) == '0);

  // F-stage lookup
  logic [BHT_IDX_W-1:0] w_bF;
  logic [HIST_W-1:0]    w_hF;
  logic [PHT_IDX_W-1:0] w_pF;
  logic [CNT_W-1:0]     w_cF;
  logic                 w_predF;

  assign w_bF    = pcF[PC_LSB +: BHT_IDX_W];
  assign w_hF    = r_bht[w_bF];
  assign w_pF    = PHT_IDX_W'(pht_hash(PHT_IDX_MAX'(w_hF),
                                       PHT_IDX_MAX'(pcF[PC_LSB +: PHT_IDX_W]), HASH_MODE));
  assign w_cF    = r_pht[w_pF];
  assign w_predF = w_cF[CNT_W-1];

  // M-stage training, computed from pre-update history
  logic [BHT_IDX_W-1:0] w_bM;
  logic [HIST_W-1:0]    w_hM;
  logic [HIST_W-1:0]    w_hM_next;
  logic [PHT_IDX_W-1:0] w_pM;
  logic [CNT_W-1:0]     w_cM;
  logic [CNT_W-1:0]     w_cM_next;
  logic                 w_train_we;

  assign w_bM       = pcM[PC_LSB +: BHT_IDX_W];
  assign w_hM       = r_bht[w_bM];
  assign w_hM_next  = {w_hM[HIST_W-2:0], actual_takeM};
  assign w_pM       = PHT_IDX_W'(pht_hash(PHT_IDX_MAX'(w_hM),
                                          PHT_IDX_MAX'(pcM[PC_LSB +: PHT_IDX_W]), HASH_MODE));
  assign w_cM       = r_pht[w_pM];
  assign w_cM_next  = CNT_W'(sat_next(CNT_W_MAX'(w_cM), actual_takeM, CNT_W));
  assign w_train_we = w_ready & branchM & ~rst;

  // BHT write port: init sweep has priority, then training
  always_ff @(posedge clk) begin
    if (w_init_we) begin
      if (w_init_bht_ok) r_bht[w_init_idx[BHT_IDX_W-1:0]] <= '0;
    end else if (w_train_we) begin
      r_bht[w_bM] <= w_hM_next;
    end
  end

  // PHT write port: init sweep loads weak-taken, then training
  always_ff @(posedge clk) begin
    if (w_init_we) begin
      if (w_init_pht_ok) r_pht[w_init_idx[PHT_IDX_W-1:0]] <= PHT_INIT;
    end else if (w_train_we) begin
      r_pht[w_pM] <= w_cM_next;
    end
  end

  // D-stage prediction register: flush beats stall; gated until tables are ready
  logic r_pred;
  always_ff @(posedge clk) begin
    if (rst || flushD) r_pred <= 1'b0;
    else if (!stallD)  r_pred <= w_predF & w_ready;
  end

  assign pred_takeD = branchD & r_pred;
  assign ready      = w_ready;

`ifdef BP_LOCAL_PERF_EN
  logic [31:0] r_br_cnt;
  logic [31:0] r_mis_cnt;

  // Resolved-branch and mispredict counters, wrapping modulo 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else if (w_train_we) begin
      r_br_cnt <= r_br_cnt + 32'd1;
      if (pred_takeM != actual_takeM) r_mis_cnt <= r_mis_cnt + 32'd1;
    end
  end

  assign perf_br_cnt  = r_br_cnt;
  assign perf_mis_cnt = r_mis_cnt;
`else
  assign perf_br_cnt  = 32'd0;
  assign perf_mis_cnt = 32'd0;
`endif

  // Bits intentionally not consumed (upper PC bits, counter LSBs, perf-only input)
  logic w_unused;
  assign w_unused = ^{pcF, pcM, pred_takeM, w_cF};

endmodule
